// File: rtl/mapper_pkg.sv
// Shared frame definitions for the mapper/demapper pair: alignment bytes,
// CRC polynomial, position counter widths and the framer state encoding.
package mapper_pkg;

    localparam logic [7:0] FAS0_DEF = 8'hF6;
    localparam logic [7:0] FAS1_DEF = 8'h28;
    localparam logic [7:0] CRC_POLY = 8'h07;

    localparam int ROW_W = 2;
    localparam int COL_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FAS  = 2'd1,
        ST_PYLD = 2'd2,
        ST_CRC  = 2'd3
    } state_e;

endpackage

// File: rtl/mapper_if.sv
// Payload-in / line-out handshake bundle; slave is the mapper side.
interface mapper_if;

    logic [7:0] i_pyld_data;
    logic       i_pyld_data_valid;
    logic       o_pyld_data_req;
    logic [7:0] o_frame_data;
    logic       o_frame_data_valid;
    logic       o_frame_data_fas;
    logic       i_frame_ready;
    logic [7:0] o_crc_val;

    modport slave (
        input  i_pyld_data,
        input  i_pyld_data_valid,
        output o_pyld_data_req,
        output o_frame_data,
        output o_frame_data_valid,
        output o_frame_data_fas,
        input  i_frame_ready,
        output o_crc_val
    );

    modport master (
        output i_pyld_data,
        output i_pyld_data_valid,
        input  o_pyld_data_req,
        input  o_frame_data,
        input  o_frame_data_valid,
        input  o_frame_data_fas,
        output i_frame_ready,
        input  o_crc_val
    );

endinterface

// File: rtl/crc8_byte.sv
// One-byte CRC-8 update, MSB first, no reflection; shared with the demapper.
module crc8_byte
    import mapper_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/mapper.sv
// Frame mapper: wraps client bytes into 4 x COLS frames with a two-byte
// alignment word up front and a CRC-8 of the payload in the last slot.
module mapper
    import mapper_pkg::*;
#(
    parameter int         COLS = 1024,
    parameter logic [7:0] FAS0 = FAS0_DEF,
    parameter logic [7:0] FAS1 = FAS1_DEF
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    mapper_if.slave bus
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_CRC  = COL_W'(COLS - 2);
    localparam logic [ROW_W-1:0] ROW_LAST = '1;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       acc_q, acc_d;
    logic [7:0]       dat_q, dat_d;
    logic             vld_q, vld_d;
    logic             fas_q, fas_d;
    logic [7:0]       crcv_q, crcv_d;

    logic             adv;
    logic             accept;
    logic             last_pyld;
    logic [7:0]       crc_next;

    // The output stage may take a new byte when empty or being drained.
    assign adv       = !vld_q || bus.i_frame_ready;
    assign accept    = (state_q == ST_PYLD) && adv && bus.i_pyld_data_valid;
    assign last_pyld = (row_q == ROW_LAST) && (col_q == COL_CRC);

    crc8_byte u_crc (
        .crc_in  (acc_q),
        .data    (bus.i_pyld_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            acc_q   <= 8'h00;
            dat_q   <= 8'h00;
            vld_q   <= 1'b0;
            fas_q   <= 1'b0;
            crcv_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            fas_q   <= fas_d;
            crcv_q  <= crcv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_pyld_data_valid) state_d = ST_FAS;
            ST_FAS:  if (adv && col_q == COL_W'(1)) state_d = ST_PYLD;
            ST_PYLD: if (accept && last_pyld) state_d = ST_CRC;
            ST_CRC:  if (adv) state_d = bus.i_pyld_data_valid ? ST_FAS : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        acc_d  = acc_q;
        dat_d  = dat_q;
        vld_d  = vld_q;
        fas_d  = fas_q;
        crcv_d = crcv_q;
        bus.o_pyld_data_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (adv) begin
                    vld_d = 1'b0;
                    fas_d = 1'b0;
                end
            end
            ST_FAS: begin
                if (adv) begin
                    vld_d = 1'b1;
                    col_d = col_q + COL_W'(1);
                    if (col_q == '0) begin
                        dat_d = FAS0;
                        fas_d = 1'b1;
                    end else begin
                        dat_d = FAS1;
                        fas_d = 1'b0;
                    end
                end
            end
            ST_PYLD: begin
                bus.o_pyld_data_req = adv;
                if (accept) begin
                    dat_d = bus.i_pyld_data;
                    vld_d = 1'b1;
                    fas_d = 1'b0;
                    acc_d = crc_next;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else if (adv) begin
                    // Source starved: drop valid, keep the frame position.
                    vld_d = 1'b0;
                    fas_d = 1'b0;
                end
            end
            ST_CRC: begin
                if (adv) begin
                    dat_d  = acc_q;
                    vld_d  = 1'b1;
                    fas_d  = 1'b0;
                    crcv_d = acc_q;
                    col_d  = '0;
                    row_d  = '0;
                end
            end
            default: ;
        endcase

        // Each frame's CRC covers only its own payload.
        if (state_d == ST_FAS && state_q != ST_FAS) begin
            acc_d = 8'h00;
            row_d = '0;
            col_d = '0;
        end
    end

    assign bus.o_frame_data       = dat_q;
    assign bus.o_frame_data_valid = vld_q;
    assign bus.o_frame_data_fas   = fas_q;
    assign bus.o_crc_val          = crcv_q;

endmodule

// File: tb/tb_mapper.sv
// Scoreboard bench for mapper at COLS=4: a frame-level model queues the
// expected line stream per accepted payload byte; a monitor matches output.
module tb_mapper;

    localparam int COLS = 4;
    localparam int PAY  = 4 * COLS - 3;

    logic clk;
    logic rst_n;

    mapper_if bus ();

    mapper #(.COLS(COLS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [7:0] crc_din;
    logic [7:0] crc_dout;
    crc8_byte u_crc_unit (
        .crc_in  (8'h00),
        .data    (crc_din),
        .crc_out (crc_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Long-division form of CRC-8 over GF(2) with generator x^8+x^2+x+1.
    function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] b);
        logic [15:0] v;
        v = {crc ^ b, 8'h00};
        for (int i = 15; i >= 8; i--)
            if (v[i]) v = v ^ (16'h0107 << (i - 8));
        return v[7:0];
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       fas;
        logic       is_crc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       fas;
        logic [7:0] crcv;
        int         cyc;
    } obs_t;

    exp_t expq[$];
    obs_t obsq[$];

    int         m_cnt = 0;
    logic [7:0] m_crc = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            m_cnt = 0;
            m_crc = 8'h00;
        end else if (bus.i_pyld_data_valid && bus.o_pyld_data_req) begin
            if (m_cnt == 0) begin
                expq.push_back('{8'hF6, 1'b1, 1'b0});
                expq.push_back('{8'h28, 1'b0, 1'b0});
                m_crc = 8'h00;
            end
            expq.push_back('{bus.i_pyld_data, 1'b0, 1'b0});
            m_crc = crc_ref(m_crc, bus.i_pyld_data);
            m_cnt++;
            if (m_cnt == PAY) begin
                expq.push_back('{m_crc, 1'b0, 1'b1});
                m_cnt = 0;
            end
        end
    end

    int         cyc = 0;
    bit         held = 0;
    logic [7:0] hd;
    logic       hf;
    bit         gap_mode = 0;
    bit         last_was_crc = 0;
    int         last_crc_cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        obs_t o;
        cyc++;
        if (!rst_n) begin
            obsq.delete();
            held = 0;
        end else begin
            if (held)
                chk(bus.o_frame_data_valid && bus.o_frame_data == hd && bus.o_frame_data_fas == hf,
                    "hold_stable", {23'd0, bus.o_frame_data_valid, bus.o_frame_data}, {24'd1, hd});
            held = bus.o_frame_data_valid && !bus.i_frame_ready;
            hd   = bus.o_frame_data;
            hf   = bus.o_frame_data_fas;
            if (bus.o_frame_data_valid && bus.i_frame_ready)
                obsq.push_back('{bus.o_frame_data, bus.o_frame_data_fas, bus.o_crc_val, cyc});
            while (expq.size() > 0 && obsq.size() > 0) begin
                e = expq.pop_front();
                o = obsq.pop_front();
                chk(o.data == e.data && o.fas == e.fas, "stream",
                    {23'd0, o.fas, o.data}, {23'd0, e.fas, e.data});
                if (e.is_crc)
                    chk(o.crcv == e.data, "crc_val", o.crcv, e.data);
                if (gap_mode && e.fas && last_was_crc)
                    chk(o.cyc == last_crc_cyc + 1, "frame_gap", o.cyc - last_crc_cyc, 1);
                last_was_crc = e.is_crc;
                if (e.is_crc) last_crc_cyc = o.cyc;
            end
        end
    end

    logic [7:0] sendq[$];
    int vld_mode = 0;
    int rdy_mode = 0;
    int gap_after = 0;
    int abort_after = 0;
    int sent = 0;

    task automatic set_ready();
        case (rdy_mode)
            0: bus.i_frame_ready = 1'b1;
            1: bus.i_frame_ready = ~bus.i_frame_ready;
            default: bus.i_frame_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic drive_in(input int gap_cnt);
        bus.i_pyld_data_valid = (sendq.size() > 0) && (gap_cnt == 0) &&
                                (vld_mode == 0 || $urandom_range(0, 3) != 0);
        if (sendq.size() > 0) bus.i_pyld_data = sendq[0];
    endtask

    task automatic run_send(input int budget);
        int gap_cnt = 0;
        bit acc;
        bit done = 0;
        sent = 0;
        set_ready();
        drive_in(0);
        while (!done) begin
            @(negedge clk);
            acc = bus.i_pyld_data_valid && bus.o_pyld_data_req;
            if (gap_cnt >= 1 && gap_cnt <= 4)
                chk(!bus.o_frame_data_valid, "gap_no_fill", {31'd0, bus.o_frame_data_valid}, 0);
            @(posedge clk);
            #1;
            budget--;
            if (acc) begin
                sendq.delete(0);
                sent++;
            end
            if (gap_cnt > 0) gap_cnt--;
            if (acc && gap_after > 0 && sent == gap_after) gap_cnt = 5;
            if (acc && abort_after > 0 && sent == abort_after) begin
                rst_n = 1'b0;
                sendq.delete();
                done = 1;
            end else if (sendq.size() == 0) begin
                done = 1;
            end else if (budget <= 0) begin
                chk(1'b0, "send_timeout", sendq.size(), 0);
                sendq.delete();
                done = 1;
            end else begin
                set_ready();
                drive_in(gap_cnt);
            end
        end
        bus.i_pyld_data_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.i_pyld_data_valid = 1'b0;
        bus.i_frame_ready     = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(bus.o_frame_data == 8'h00, {tag, "_data"}, bus.o_frame_data, 0);
        chk(!bus.o_frame_data_valid, {tag, "_valid"}, {31'd0, bus.o_frame_data_valid}, 0);
        chk(!bus.o_frame_data_fas, {tag, "_fas"}, {31'd0, bus.o_frame_data_fas}, 0);
        chk(!bus.o_pyld_data_req, {tag, "_req"}, {31'd0, bus.o_pyld_data_req}, 0);
        chk(bus.o_crc_val == 8'h00, {tag, "_crc"}, bus.o_crc_val, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.i_pyld_data = 8'h00;
        bus.i_pyld_data_valid = 1'b0;
        bus.i_frame_ready = 1'b1;
        crc_din = 8'h01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        chk(crc_dout == 8'h07, "crc8_of_01", crc_dout, 8'h07);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain(2);

        // Frame of zeros, ready held high.
        for (int i = 0; i < PAY; i++) sendq.push_back(8'h00);
        run_send(400);
        drain(10);

        // Single 0x01 then zeros.
        sendq.push_back(8'h01);
        for (int i = 1; i < PAY; i++) sendq.push_back(8'h00);
        run_send(400);
        drain(10);

        // Counting payload with ready toggling every cycle.
        rdy_mode = 1;
        for (int i = 1; i <= PAY; i++) sendq.push_back(8'(i));
        run_send(400);
        rdy_mode = 0;
        drain(10);

        // Source pause of 5 cycles after the sixth payload byte.
        gap_after = 6;
        for (int i = 1; i <= PAY; i++) sendq.push_back(8'(i + 8'h40));
        run_send(400);
        gap_after = 0;
        drain(10);

        // Two back-to-back frames of zeros: no gap between CRC and next FAS.
        last_was_crc = 0;
        gap_mode = 1;
        for (int i = 0; i < 2 * PAY; i++) sendq.push_back(8'h00);
        run_send(800);
        drain(10);
        gap_mode = 0;

        // Random data, random source valid, random sink ready.
        vld_mode = 1;
        rdy_mode = 2;
        for (int i = 0; i < 10 * PAY; i++) sendq.push_back(8'($urandom_range(0, 255)));
        run_send(10000);
        vld_mode = 0;
        rdy_mode = 0;
        drain(20);
        chk(!bus.o_pyld_data_req, "idle_req_low", {31'd0, bus.o_pyld_data_req}, 0);
        chk(!bus.o_frame_data_valid, "idle_valid_low", {31'd0, bus.o_frame_data_valid}, 0);

        // Reset in the middle of the payload, then a fresh frame.
        abort_after = 6;
        for (int i = 1; i <= PAY; i++) sendq.push_back(8'(i + 8'h80));
        run_send(400);
        abort_after = 0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= PAY; i++) sendq.push_back(8'(i + 8'hC0));
        run_send(400);
        drain(20);

        chk(expq.size() == 0, "expected_left", expq.size(), 0);
        chk(obsq.size() == 0, "observed_left", obsq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mapper.md
MAPPER -- requirements
Module: mapper

Interface
REQ-001 SHALL have parameter COLS, default 1024, columns per frame row (legal range 4..2048).
REQ-002 SHALL have parameter FAS0, default 8'hF6, first frame alignment byte.
REQ-003 SHALL have parameter FAS1, default 8'h28, second frame alignment byte.
REQ-004 i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_pyld_data  input  8  client payload byte, from the rx AXIS FIFO.
REQ-007 i_pyld_data_valid  input  1  client byte valid.
REQ-008 o_pyld_data_req  output  1  mapper ready; byte accepted when i_pyld_data_valid and o_pyld_data_req are both high.
REQ-009 o_frame_data  output  8  line byte to the serial transmitter.
REQ-010 o_frame_data_valid  output  1  line byte valid.
REQ-011 o_frame_data_fas  output  1  high with the first FAS byte only.
REQ-012 i_frame_ready  input  1  serial transmitter accepts the line byte this cycle.
REQ-013 o_crc_val  output  8  CRC of the last completed frame.

Function
REQ-014 Frame SHALL be 4 rows x COLS bytes: row0/col0 = FAS0, row0/col1 = FAS1, row3/col COLS-1 = CRC byte, all other positions = payload (4*COLS-3 bytes).
REQ-015 Output SHALL be one register stage; adv = !o_frame_data_valid | i_frame_ready; the stage loads only when adv is high, else holds data/valid/fas stable.
REQ-016 FSM states: IDLE, FAS, PYLD, CRC.
REQ-017 IDLE -> FAS when i_pyld_data_valid is high; no byte is emitted in IDLE.
REQ-018 FAS: on each adv, load FAS0 (fas=1) then FAS1 (fas=0); after FAS1 -> PYLD.
REQ-019 PYLD: o_pyld_data_req = adv; each accepted byte loads the output stage and advances the position; when adv is high but valid is low, load nothing (valid falls, position holds).
REQ-020 Leaving PYLD: after row3/col COLS-2 is accepted -> CRC.
REQ-021 CRC: on adv, load the CRC byte and update o_crc_val with the same value; then -> FAS if i_pyld_data_valid is high, else -> IDLE.
REQ-022 o_pyld_data_req SHALL be 0 in every state except PYLD.
REQ-023 Position counters: row 2 bits, col 11 bits; col wraps COLS-1 -> 0 and increments row; row wraps 3 -> 0 at frame end.
REQ-024 CRC-8 SHALL use polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR, computed over the accepted payload bytes of the current frame only.
REQ-025 CRC accumulator SHALL reset to 0x00 on entry to FAS.
REQ-026 Latency: an accepted payload byte SHALL appear on o_frame_data on the next cycle.
REQ-027 Backpressure SHALL lose or duplicate no byte; a byte stays stable while valid & !i_frame_ready.

Reset
REQ-028 While i_rst_n is low: FSM = IDLE, counters = 0, CRC accumulator = 0x00, o_frame_data = 0x00, o_frame_data_valid = 0, o_frame_data_fas = 0, o_pyld_data_req = 0, o_crc_val = 0x00.
REQ-029 Reset asserted mid-frame SHALL abandon the partial frame; after release, the next output is a fresh FAS0.

Structure
REQ-030 A shared frame package SHALL hold FAS0/FAS1 defaults, the CRC polynomial, row/col widths and the FSM state encoding; the demapper uses the same package.
REQ-031 The CRC-8 byte update SHALL be one combinational sub-module, crc8_byte (inputs crc_in and data; output crc_out), shared with the demapper.

Verification (COLS=4: 16-byte frame, 13 payload bytes)
REQ-032 13 x 0x00 continuous, ready=1 -> F6(fas=1), 28, 13 x 00, CRC 00; o_crc_val = 00.
REQ-033 One byte 0x01 then 12 x 0x00 -> CRC byte equals the bench CRC-8/0x07 model; a single-byte check gives crc8(0x01) = 0x07.
REQ-034 Payload 0x01..0x0D, i_frame_ready toggles 1/0 -> output sequence identical to the ready=1 run; held bytes stay stable.
REQ-035 i_pyld_data_valid low for 5 cycles mid-PYLD -> valid=0 gap, no fill byte, frame resumes at the same position.
REQ-036 Continuous payload across 2 frames -> second F6 follows the first CRC byte with no gap; the CRC restarts (frame 2 all-zero -> 00).
REQ-037 i_rst_n low at payload byte 6 -> all outputs at reset values; after release, the next valid byte is F6 with fas=1.
